// File: rtl/shared_bram_pingpong_capture.sv
// Ping-pong frame capture into two banks of one dual-port memory; the bus reads and byte-writes the read bank.
// Fabric writes land on the next edge; bus reads return RD_LATENCY (1 or 2) cycles after the request, fully pipelined.
// No backpressure: a frame that completes while software still holds the read bank is dropped and flagged.
module shared_bram_pingpong_capture #(
  parameter  int DWIDTH     = 32,
  parameter  int AWIDTH     = 10,
  parameter  int RD_LATENCY = 2,
  localparam int NUM_WE     = DWIDTH / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm_i,
  input  logic              sync_i,
  input  logic              din_valid_i,
  input  logic [DWIDTH-1:0] din_i,
  input  logic              ack_i,
  input  logic              bus_en_i,
  input  logic [NUM_WE-1:0] bus_we_i,
  input  logic [AWIDTH-1:0] bus_addr_i,
  input  logic [DWIDTH-1:0] bus_wr_data_i,
  output logic [DWIDTH-1:0] bus_rd_data_o,
  output logic              bus_rd_valid_o,
  output logic              rd_bank_o,
  output logic [15:0]       frame_count_o,
  output logic              overflow_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    CAPTURE   = 2'd2
  } state_t;

  state_t            state_q;
  logic [AWIDTH-1:0] wr_ptr_q;
  logic              rd_bank_q;
  logic              rd_free_q;
  logic              arm_q;
  logic              overflow_q;
  logic [15:0]       frame_count_q;

  // Bank 0 occupies the lower half of the array, bank 1 the upper half.
  logic [DWIDTH-1:0] mem_q [2**(AWIDTH+1)];

  logic              frame_sync;
  logic              fab_we;
  logic [AWIDTH-1:0] fab_addr;
  logic              frame_done;
  logic              rd_free_now;
  logic              do_swap;
  logic              drop;
  logic              bus_rd;
  logic              bus_wr;
  logic [AWIDTH:0]   fab_idx;
  logic [AWIDTH:0]   bus_idx;

  // A sync seen while armed (waiting or mid-frame) restarts the frame at address 0.
  assign frame_sync  = arm_i && sync_i && (state_q == WAIT_SYNC || state_q == CAPTURE);
  assign fab_we      = arm_i && din_valid_i && (state_q == CAPTURE || frame_sync);
  assign fab_addr    = frame_sync ? '0 : wr_ptr_q;
  assign frame_done  = fab_we && !frame_sync && (wr_ptr_q == '1);
  // An ack arriving on the completion cycle already frees the read bank.
  assign rd_free_now = rd_free_q || ack_i;
  assign do_swap     = frame_done && rd_free_now;
  assign drop        = frame_done && !rd_free_now;

  // The fabric only ever targets the write bank and the bus only the read bank.
  assign fab_idx = {~rd_bank_q, fab_addr};
  assign bus_idx = {rd_bank_q, bus_addr_i};
  assign bus_rd  = bus_en_i && (bus_we_i == '0);
  assign bus_wr  = bus_en_i && (bus_we_i != '0);

  // Capture FSM together with bank ownership, frame counter and drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_bank_q     <= 1'b1;
      rd_free_q     <= 1'b1;
      arm_q         <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      arm_q <= arm_i;

      if (arm_i && !arm_q) begin
        overflow_q <= 1'b0;
      end else if (drop) begin
        overflow_q <= 1'b1;
      end

      if (do_swap) begin
        rd_bank_q     <= ~rd_bank_q;
        frame_count_q <= frame_count_q + 16'd1;
        rd_free_q     <= 1'b0;
      end else if (ack_i) begin
        rd_free_q <= 1'b1;
      end

      if (!arm_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= WAIT_SYNC;
          end
          WAIT_SYNC: begin
            if (sync_i) begin
              state_q  <= CAPTURE;
              wr_ptr_q <= AWIDTH'(din_valid_i);
            end
          end
          CAPTURE: begin
            if (sync_i) begin
              wr_ptr_q <= AWIDTH'(din_valid_i);
            end else if (din_valid_i) begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
              if (frame_done) begin
                state_q <= WAIT_SYNC;
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // Memory write ports: fabric whole-word writes and bus byte-lane writes.
  always_ff @(posedge clk) begin
    if (fab_we) begin
      mem_q[fab_idx] <= din_i;
    end
    if (bus_wr) begin
      for (int b = 0; b < NUM_WE; b++) begin
        if (bus_we_i[b]) begin
          mem_q[bus_idx][b*8 +: 8] <= bus_wr_data_i[b*8 +: 8];
        end
      end
    end
  end

  logic [DWIDTH-1:0] rd_raw_q;
  logic              rd_vld1_q;

  // First read stage: bank and address are taken from the request cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_raw_q  <= '0;
      rd_vld1_q <= 1'b0;
    end else begin
      rd_vld1_q <= bus_rd;
      if (bus_rd) begin
        rd_raw_q <= mem_q[bus_idx];
      end
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    assign bus_rd_data_o  = rd_raw_q;
    assign bus_rd_valid_o = rd_vld1_q;
  end else begin : g_lat2
    logic [DWIDTH-1:0] rd_dat2_q;
    logic              rd_vld2_q;

    // Second read stage; data holds its last value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_dat2_q <= '0;
        rd_vld2_q <= 1'b0;
      end else begin
        rd_vld2_q <= rd_vld1_q;
        if (rd_vld1_q) begin
          rd_dat2_q <= rd_raw_q;
        end
      end
    end

    assign bus_rd_data_o  = rd_dat2_q;
    assign bus_rd_valid_o = rd_vld2_q;
  end

  assign rd_bank_o     = rd_bank_q;
  assign frame_count_o = frame_count_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_shared_bram_pingpong_capture.sv
module tb_shared_bram_pingpong_capture;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        sync;
  logic        din_valid;
  logic [31:0] din;
  logic        ack;
  logic        bus_en;
  logic [3:0]  bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wr_data;

  logic [31:0] d2_data, d1_data;
  logic        d2_valid, d1_valid;
  logic        d2_bank, d1_bank;
  logic [15:0] d2_cnt, d1_cnt;
  logic        d2_ovf, d1_ovf;

  int passed = 0;
  int total  = 0;

  shared_bram_pingpong_capture #(.DWIDTH(32), .AWIDTH(4), .RD_LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .arm_i(arm), .sync_i(sync), .din_valid_i(din_valid),
    .din_i(din), .ack_i(ack), .bus_en_i(bus_en), .bus_we_i(bus_we), .bus_addr_i(bus_addr),
    .bus_wr_data_i(bus_wr_data), .bus_rd_data_o(d2_data), .bus_rd_valid_o(d2_valid),
    .rd_bank_o(d2_bank), .frame_count_o(d2_cnt), .overflow_o(d2_ovf)
  );

  shared_bram_pingpong_capture #(.DWIDTH(32), .AWIDTH(4), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .arm_i(arm), .sync_i(sync), .din_valid_i(din_valid),
    .din_i(din), .ack_i(ack), .bus_en_i(bus_en), .bus_we_i(bus_we), .bus_addr_i(bus_addr),
    .bus_wr_data_i(bus_wr_data), .bus_rd_data_o(d1_data), .bus_rd_valid_o(d1_valid),
    .rd_bank_o(d1_bank), .frame_count_o(d1_cnt), .overflow_o(d1_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] base;
    bit          gaps;
    bit          toggle_arm;
    bit          ack_first;
    bit          bytewr;
    logic        exp_bank;
    logic [15:0] exp_cnt;
    logic        exp_ovf;
    logic [31:0] rd_base;
  } frame_vec_t;

  frame_vec_t vecs [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic chk_status(input string nm, input logic bank, input logic [15:0] cnt, input logic ovf);
    chk({nm, " rd_bank"},      32'(d2_bank), 32'(bank));
    chk({nm, " frame_count"},  32'(d2_cnt),  32'(cnt));
    chk({nm, " overflow"},     32'(d2_ovf),  32'(ovf));
    chk({nm, " lat1 rd_bank"}, 32'(d1_bank), 32'(bank));
  endtask

  // Streams n valid words base..base+n-1 with sync on the first cycle; optional gap every 3rd cycle
  // and an optional bus read issued on the cycle of the final word.
  task automatic feed(input logic [31:0] base, input int n, input bit gaps,
                      input bit rd_last, input logic [3:0] rd_addr);
    int k = 0;
    int c = 0;
    while (k < n) begin
      sync = (c == 0);
      if (gaps && (c % 3 == 2)) begin
        din_valid = 1'b0;
      end else begin
        din_valid = 1'b1;
        din       = base + 32'(k);
        if (rd_last && k == n - 1) begin
          bus_en   = 1'b1;
          bus_we   = 4'b0000;
          bus_addr = rd_addr;
        end
        k++;
      end
      step();
      bus_en = 1'b0;
      c++;
    end
    sync      = 1'b0;
    din_valid = 1'b0;
  endtask

  // Back-to-back reads of addresses 0..15, expecting base+addr with exact latency on both instances.
  task automatic burst(input logic [31:0] base, input string nm);
    for (int c = 0; c < 18; c++) begin
      logic ev1, ev2;
      ev1 = (c >= 1 && c <= 16);
      ev2 = (c >= 2 && c <= 17);
      chk($sformatf("%s lat1 valid c%0d", nm, c), 32'(d1_valid), 32'(ev1));
      chk($sformatf("%s lat2 valid c%0d", nm, c), 32'(d2_valid), 32'(ev2));
      if (ev1) chk($sformatf("%s lat1 data c%0d", nm, c), d1_data, base + 32'(c - 1));
      if (ev2) chk($sformatf("%s lat2 data c%0d", nm, c), d2_data, base + 32'(c - 2));
      bus_en   = (c < 16);
      bus_we   = 4'b0000;
      bus_addr = 4'(c);
      step();
    end
    chk({nm, " lat2 data hold"}, d2_data, base + 32'd15);
    chk({nm, " lat2 valid idle"}, 32'(d2_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0, 32'd0};
    vecs[1] = '{32'd100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 32'd0};
    vecs[2] = '{32'd200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2, 1'b0, 32'd200};
    vecs[3] = '{32'd300, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 32'd300};

    rst_n = 1'b0; arm = 1'b0; sync = 1'b0; din_valid = 1'b0; din = '0; ack = 1'b0;
    bus_en = 1'b0; bus_we = '0; bus_addr = '0; bus_wr_data = '0;
    step();
    step();
    chk_status("reset", 1'b1, 16'd0, 1'b0);
    chk("reset lat2 valid", 32'(d2_valid), 32'd0);
    chk("reset lat2 data",  d2_data, 32'd0);
    chk("reset lat1 data",  d1_data, 32'd0);

    rst_n = 1'b1;
    step();
    arm = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].toggle_arm) begin
        arm = 1'b0;
        step();
        arm = 1'b1;
        step();
        chk($sformatf("vec%0d arm edge clears overflow", i), 32'(d2_ovf), 32'd0);
      end
      if (vecs[i].ack_first) pulse_ack();
      feed(vecs[i].base, 16, vecs[i].gaps, 1'b0, 4'd0);
      chk_status($sformatf("vec%0d", i), vecs[i].exp_bank, vecs[i].exp_cnt, vecs[i].exp_ovf);
      burst(vecs[i].rd_base, $sformatf("vec%0d read", i));
      if (vecs[i].bytewr) begin
        bus_en = 1'b1; bus_we = 4'b0011; bus_addr = 4'd5; bus_wr_data = 32'hAABBCCDD;
        step();
        bus_en = 1'b0; bus_we = 4'b0000;
        chk("bytewr no lat1 valid", 32'(d1_valid), 32'd0);
        step();
        chk("bytewr no lat2 valid", 32'(d2_valid), 32'd0);
        bus_en = 1'b1; bus_addr = 4'd5;
        step();
        bus_en = 1'b0;
        chk("bytewr lat1 valid", 32'(d1_valid), 32'd1);
        chk("bytewr lat1 data",  d1_data, 32'h0000CCDD);
        step();
        chk("bytewr lat2 valid", 32'(d2_valid), 32'd1);
        chk("bytewr lat2 data",  d2_data, 32'h0000CCDD);
      end
    end

    // Resync after 7 words: the partial frame must not complete or count.
    pulse_ack();
    feed(32'd600, 7, 1'b0, 1'b0, 4'd0);
    chk_status("partial before resync", 1'b0, 16'd3, 1'b0);
    feed(32'd400, 16, 1'b0, 1'b0, 4'd0);
    chk_status("after resync", 1'b1, 16'd4, 1'b0);
    burst(32'd400, "resync read");

    // Read issued on the swap cycle returns data from the bank being released.
    pulse_ack();
    feed(32'd500, 16, 1'b0, 1'b1, 4'd5);
    chk_status("swap-cycle", 1'b0, 16'd5, 1'b0);
    chk("swap-cycle lat1 valid", 32'(d1_valid), 32'd1);
    chk("swap-cycle lat1 data",  d1_data, 32'd405);
    chk("swap-cycle lat2 early", 32'(d2_valid), 32'd0);
    step();
    chk("swap-cycle lat2 valid", 32'(d2_valid), 32'd1);
    chk("swap-cycle lat2 data",  d2_data, 32'd405);
    chk("swap-cycle lat1 drop",  32'(d1_valid), 32'd0);

    // arm drops at word 9: remaining words are ignored and nothing swaps.
    pulse_ack();
    feed(32'd700, 9, 1'b0, 1'b0, 4'd0);
    arm = 1'b0;
    for (int k = 9; k < 16; k++) begin
      din_valid = 1'b1;
      din       = 32'd700 + 32'(k);
      step();
    end
    din_valid = 1'b0;
    chk_status("arm drop", 1'b0, 16'd5, 1'b0);
    arm = 1'b1;
    step();
    feed(32'd800, 16, 1'b0, 1'b0, 4'd0);
    chk_status("after re-arm", 1'b1, 16'd6, 1'b0);
    burst(32'd800, "re-arm read");

    // Build non-reset state everywhere, then reset asynchronously mid-frame.
    pulse_ack();
    feed(32'd900, 16, 1'b0, 1'b0, 4'd0);
    feed(32'd1000, 16, 1'b0, 1'b0, 4'd0);
    chk_status("pre-reset", 1'b0, 16'd7, 1'b1);
    feed(32'd1100, 5, 1'b0, 1'b0, 4'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_status("async reset", 1'b1, 16'd0, 1'b0);
    chk("async reset lat2 data",  d2_data, 32'd0);
    chk("async reset lat1 data",  d1_data, 32'd0);
    chk("async reset lat2 valid", 32'(d2_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
